ad_ip_jesd204_tpl_adc_capture: RTL

AD_IP_JESD204_TPL_ADC_CAPTURE -- requirements
Module: ad_ip_jesd204_tpl_adc_capture

---
 rtl/ad_ip_jesd204_tpl_adc_capture.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Length-bounded ADC capture engine: arms on transport sync and buffers
// formatted beats in a small FIFO. The FIFO drains onto an AXI-stream
// master, and the final beat of a capture is tagged with m_axis_last.
module ad_ip_jesd204_tpl_adc_capture #(
  parameter int NUM_CHANNELS    = 1,
  parameter int BITS_PER_SAMPLE = 16,
  parameter int DATA_PATH_WIDTH = 1,
  parameter int FIFO_ADDR_WIDTH = 4,
  localparam int unsigned DMA_DATA_WIDTH = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CHANNELS-1:0]   adc_valid,
  input  logic [DMA_DATA_WIDTH-1:0] adc_data,
  input  logic                      adc_sync_status,
  input  logic                      capture_start,
  input  logic                      capture_abort,
  input  logic [31:0]               capture_length,
  output logic                      m_axis_valid,
  input  logic                      m_axis_ready,
  output logic [DMA_DATA_WIDTH-1:0] m_axis_data,
  output logic                      m_axis_last,
  output logic                      capture_busy,
  output logic                      capture_overflow
);

  localparam int unsigned AW      = FIFO_ADDR_WIDTH;
  localparam int unsigned CW      = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned DEPTH   = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned ENTRY_W = DMA_DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         beat_cnt_q, beat_cnt_d;
  logic                ovf_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  head_d;
  logic                beat, wr_last, wr_en, rd_en, full, flush;

  // Only channel 0 qualifies beats; the other valid bits are intentionally ignored.
  logic unused_valid_c;
  assign unused_valid_c = ^adc_valid;

  // Next-state, beat accounting and FIFO pointer arithmetic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    ovf_d      = capture_overflow;
    beat       = 1'b0;
    wr_last    = 1'b0;
    flush      = 1'b0;
    rd_en      = m_axis_valid && m_axis_ready;
    full       = (count_q == CW'(DEPTH));

    case (state_q)
      IDLE: begin
        if (capture_start && (capture_length != 32'd0)) begin
          ovf_d      = 1'b0;
          beat_cnt_d = 32'd0;
          len_d      = capture_length;
          state_d    = adc_sync_status ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (!adc_sync_status) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (adc_valid[0]) begin
          beat       = 1'b1;
          wr_last    = (beat_cnt_q == (len_q - 32'd1));
          beat_cnt_d = beat_cnt_q + 32'd1;
          if (full && !rd_en) ovf_d = 1'b1;
          if (wr_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (count_q == CW'(0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything except reset; overflow history is kept.
    if (capture_abort) begin
      state_d    = IDLE;
      flush      = 1'b1;
      beat       = 1'b0;
      beat_cnt_d = beat_cnt_q;
      ovf_d      = capture_overflow;
    end

    wr_en = beat && !(full && !rd_en);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(rd_en);
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    end

    // New head: bypass the incoming beat when it lands at the next read slot.
    if (wr_en && (rd_ptr_d == wr_ptr_q)) head_d = {adc_data, wr_last};
    else                                 head_d = mem[rd_ptr_d];
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q          <= IDLE;
      len_q            <= 32'd0;
      beat_cnt_q       <= 32'd0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      m_axis_valid     <= 1'b0;
      m_axis_last      <= 1'b0;
      capture_busy     <= 1'b0;
      capture_overflow <= 1'b0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      beat_cnt_q       <= beat_cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      m_axis_valid     <= (count_d != CW'(0));
      m_axis_last      <= (count_d != CW'(0)) ? head_d[0] : 1'b0;
      capture_busy     <= (state_d != IDLE);
      capture_overflow <= ovf_d;
    end
  end

  // FIFO storage and output data register; neither needs a reset value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {adc_data, wr_last};
    if (count_d != CW'(0)) m_axis_data <= head_d[ENTRY_W-1:1];
  end

endmodule
